mem_access_unit: RTL and testbench

- Initiator side of the data-memory interface. Sits in the CPU MEM stage, between pipeline and data memory.
- Accepts one load/store per instruction using the 3-bit DM_ctrl encoding: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW, 101 SB, 110 SH, 111 SW.
- Drives a word-wide memory bus with byte enables and a ready handshake; stalls the pipeline until the access completes.
- Returns lane-aligned, sign/zero-extended load data.

---
 rtl/mem_access_unit.sv | 189 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: initiator side of the data-memory interface in the MEM stage.
// It issues one load or store per request on a word-wide bus with byte enables,
// stalls the pipeline until the bus answers or the access times out, and returns
// a lane-aligned, sign/zero-extended load result.
//
// Build option: define MAU_ALIGN_CHECK_EN to reject misaligned halfword/word
// accesses without touching the bus (addr_err pulse). When it is undefined,
// addr_err stays 0 and the ignored low address bits are simply dropped.
//
// state | meaning
// IDLE  | no access in flight; latch a request when req_valid=1
// WAIT  | bus request held stable until mem_ready or timeout
// RESP  | one-cycle done pulse with result/error; pipeline advances
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic [2:0]        DM_ctrl,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              addr_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-3:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Timer is loaded with TIMEOUT_CYCLES-1 so that reaching zero marks the
    // last permitted WAIT cycle.
    localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [7:0]  tmr;
    logic [2:0]  op_q;
    logic [1:0]  lo_q;

    size_t       size_in;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic        we_next;
    logic        misaligned;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_data;

    // Access size from the incoming operation code
    always_comb begin
        size_in = SZ_WORD;
        case (DM_ctrl)
            3'b000, 3'b001, 3'b101: size_in = SZ_BYTE;
            3'b010, 3'b011, 3'b110: size_in = SZ_HALF;
            default:                size_in = SZ_WORD;
        endcase
    end

    // Bus-side values for the request being accepted
    always_comb begin
        be_next    = 4'b1111;
        wdata_next = wdata;
        case (size_in)
            SZ_BYTE: begin
                be_next    = 4'(4'b0001 << addr[1:0]);
                wdata_next = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                be_next    = addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{wdata[15:0]}};
            end
            default: begin
                be_next    = 4'b1111;
                wdata_next = wdata;
            end
        endcase
    end

    assign we_next = DM_ctrl[2] & (DM_ctrl[1] | DM_ctrl[0]);

`ifdef MAU_ALIGN_CHECK_EN
    assign misaligned = ((size_in == SZ_HALF) && addr[0]) ||
                        ((size_in == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Load lane selection and extension from the latched operation
    always_comb begin
        byte_lane = mem_rdata[8*lo_q +: 8];
        half_lane = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = 32'h0;
        case (op_q)
            3'b000:  load_data = {{24{byte_lane[7]}}, byte_lane};
            3'b001:  load_data = {24'h0, byte_lane};
            3'b010:  load_data = {{16{half_lane[15]}}, half_lane};
            3'b011:  load_data = {16'h0, half_lane};
            3'b100:  load_data = mem_rdata;
            default: load_data = 32'h0;
        endcase
    end

    assign stall = ((state == IDLE) && req_valid) || (state == WAIT);

    // Access sequencer: bus outputs, timeout timer and response pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            tmr       <= 8'h0;
            op_q      <= 3'b000;
            lo_q      <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'b0000;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
            done      <= 1'b0;
            rdata     <= 32'h0;
            addr_err  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            done     <= 1'b0;
            addr_err <= 1'b0;
            bus_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q <= DM_ctrl;
                        lo_q <= addr[1:0];
                        if (misaligned) begin
                            rdata    <= 32'h0;
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                            state    <= RESP;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= we_next;
                            mem_be    <= be_next;
                            mem_addr  <= addr[ADDR_W-1:2];
                            mem_wdata <= wdata_next;
                            tmr       <= TMR_LOAD;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (mem_ready || (tmr == 8'h0)) begin
                        rdata   <= mem_ready ? load_data : 32'h0;
                        bus_err <= ~mem_ready;
                        done    <= 1'b1;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= 4'b0000;
                        tmr     <= 8'h0;
                        state   <= RESP;
                    end else begin
                        tmr <= tmr - 8'h1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit with TIMEOUT_CYCLES=4.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [2:0]  DM_ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        addr_err;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [29:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int checks = 0;
    int failures = 0;

    mem_access_unit #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .DM_ctrl   (DM_ctrl),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .addr_err  (addr_err),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One access with mem_ready in the first WAIT cycle; starts and ends in IDLE.
    task automatic do_access(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rword,
                             input logic [3:0] ebe, input logic ewe,
                             input logic [31:0] ewd, input logic [31:0] erd);
        req_valid = 1'b1;
        DM_ctrl   = ctrl;
        addr      = a;
        wdata     = wd;
        #1;
        chk({tag, " c0 stall"}, 32'(stall), 32'd1);
        next_cycle();
        chk({tag, " c1 mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, " c1 mem_be"}, 32'(mem_be), 32'(ebe));
        chk({tag, " c1 mem_we"}, 32'(mem_we), 32'(ewe));
        chk({tag, " c1 mem_addr"}, 32'(mem_addr), a >> 2);
        chk({tag, " c1 mem_wdata"}, mem_wdata, ewd);
        chk({tag, " c1 done"}, 32'(done), 32'd0);
        chk({tag, " c1 stall"}, 32'(stall), 32'd1);
        mem_ready = 1'b1;
        mem_rdata = rword;
        next_cycle();
        chk({tag, " c2 done"}, 32'(done), 32'd1);
        chk({tag, " c2 rdata"}, rdata, erd);
        chk({tag, " c2 stall"}, 32'(stall), 32'd0);
        chk({tag, " c2 mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, " c2 bus_err"}, 32'(bus_err), 32'd0);
        chk({tag, " c2 addr_err"}, 32'(addr_err), 32'd0);
        req_valid = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        next_cycle();
        chk({tag, " c3 done"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        DM_ctrl   = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_rdata = 32'h0;
        mem_ready = 1'b0;

        next_cycle();
        next_cycle();
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst mem_we", 32'(mem_we), 32'd0);
        chk("rst mem_be", 32'(mem_be), 32'd0);
        chk("rst mem_addr", 32'(mem_addr), 32'd0);
        chk("rst mem_wdata", mem_wdata, 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst addr_err", 32'(addr_err), 32'd0);
        chk("rst bus_err", 32'(bus_err), 32'd0);
        chk("rst stall", 32'(stall), 32'd0);
        rst_n = 1'b1;
        next_cycle();

        do_access("LB",  3'b000, 32'h0000_0103, 32'h0, 32'h80FF_1234, 4'b1000, 1'b0, 32'h0, 32'hFFFF_FF80);
        do_access("LHU", 3'b011, 32'h0000_0202, 32'h0, 32'h8001_7777, 4'b1100, 1'b0, 32'h0, 32'h0000_8001);
        do_access("SB",  3'b101, 32'h0000_0101, 32'h1234_56AB, 32'hFFFF_FFFF, 4'b0010, 1'b1, 32'hABAB_ABAB, 32'h0);
        do_access("LH",  3'b010, 32'h0000_0002, 32'h0, 32'h8001_7777, 4'b1100, 1'b0, 32'h0, 32'hFFFF_8001);
        do_access("LBU", 3'b001, 32'h0000_0011, 32'h0, 32'h0000_80FF, 4'b0010, 1'b0, 32'h0, 32'h0000_0080);
        do_access("SH",  3'b110, 32'h0000_0020, 32'h5555_BEEF, 32'h0, 4'b0011, 1'b1, 32'hBEEF_BEEF, 32'h0);
        do_access("LW",  3'b100, 32'h0000_0400, 32'h0, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);

        // SW timeout: 1 IDLE + 4 WAIT stall cycles, then done+bus_err together
        req_valid = 1'b1;
        DM_ctrl   = 3'b111;
        addr      = 32'h0000_0300;
        wdata     = 32'h1122_3344;
        #1;
        chk("TO c0 stall", 32'(stall), 32'd1);
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            chk($sformatf("TO c%0d stall", i), 32'(stall), 32'd1);
            chk($sformatf("TO c%0d mem_req", i), 32'(mem_req), 32'd1);
            chk($sformatf("TO c%0d mem_wdata", i), mem_wdata, 32'h1122_3344);
            chk($sformatf("TO c%0d done", i), 32'(done), 32'd0);
        end
        next_cycle();
        chk("TO c5 done", 32'(done), 32'd1);
        chk("TO c5 bus_err", 32'(bus_err), 32'd1);
        chk("TO c5 rdata", rdata, 32'd0);
        chk("TO c5 stall", 32'(stall), 32'd0);
        chk("TO c5 mem_req", 32'(mem_req), 32'd0);
        req_valid = 1'b0;
        next_cycle();
        chk("TO c6 done", 32'(done), 32'd0);
        chk("TO c6 bus_err", 32'(bus_err), 32'd0);
        chk("TO c6 stall", 32'(stall), 32'd0);

        // mem_ready on the last permitted WAIT cycle completes normally
        req_valid = 1'b1;
        DM_ctrl   = 3'b100;
        addr      = 32'h0000_0500;
        mem_rdata = 32'h0BAD_F00D;
        for (int i = 1; i <= 3; i++) next_cycle();
        chk("LATE c3 mem_req", 32'(mem_req), 32'd1);
        next_cycle();
        mem_ready = 1'b1;
        next_cycle();
        chk("LATE c5 done", 32'(done), 32'd1);
        chk("LATE c5 bus_err", 32'(bus_err), 32'd0);
        chk("LATE c5 rdata", rdata, 32'h0BAD_F00D);
        req_valid = 1'b0;
        mem_ready = 1'b0;
        next_cycle();

        // Reset during WAIT drops mem_req without a clock edge
        req_valid = 1'b1;
        DM_ctrl   = 3'b100;
        addr      = 32'h0000_0600;
        next_cycle();
        chk("RST c1 mem_req", 32'(mem_req), 32'd1);
        req_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("RST async mem_req", 32'(mem_req), 32'd0);
        chk("RST async stall", 32'(stall), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        next_cycle();
        chk("RST after done", 32'(done), 32'd0);
        chk("RST after mem_req", 32'(mem_req), 32'd0);
        do_access("POSTRST LW", 3'b100, 32'h0000_0700, 32'h0, 32'h1357_9BDF, 4'b1111, 1'b0, 32'h0, 32'h1357_9BDF);

`ifdef MAU_ALIGN_CHECK_EN
        // Misaligned word skips the bus: addr_err and done at cycle 1
        req_valid = 1'b1;
        DM_ctrl   = 3'b100;
        addr      = 32'h0000_0102;
        #1;
        chk("MIS c0 stall", 32'(stall), 32'd1);
        next_cycle();
        chk("MIS c1 mem_req", 32'(mem_req), 32'd0);
        chk("MIS c1 done", 32'(done), 32'd1);
        chk("MIS c1 addr_err", 32'(addr_err), 32'd1);
        chk("MIS c1 rdata", rdata, 32'd0);
        chk("MIS c1 stall", 32'(stall), 32'd0);
        req_valid = 1'b0;
        next_cycle();
        chk("MIS c2 done", 32'(done), 32'd0);
        chk("MIS c2 addr_err", 32'(addr_err), 32'd0);
        chk("MIS c2 mem_req", 32'(mem_req), 32'd0);
`else
        // Misaligned accesses drop the ignored low address bits
        do_access("MIS LW", 3'b100, 32'h0000_0102, 32'h0, 32'h89AB_CDEF, 4'b1111, 1'b0, 32'h0, 32'h89AB_CDEF);
        do_access("MIS LH", 3'b010, 32'h0000_0103, 32'h0, 32'h7FFF_8000, 4'b1100, 1'b0, 32'h0, 32'h0000_7FFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
